mmio_fabric: RTL and testbench
==============================

# mmio_fabric

Parametrised memory-mapped interconnect between the CPU data port and up to NUM_SLAVES peripherals (RAM, VRAM, joypad, palette, video regs, LCD, audio, ...). The block replaces the purely combinational top-level address decode with a registered request/ready handshake. It adds per-slave wait states, a bus timeout, error responses for unmapped regions, and a sticky error status.

## Interface
Parameters:
- NUM_SLAVES, 7, number of slave regions; legal range 1 to 2**SEL_BITS.
- SEL_BITS, 3, region index taken from m_addr[31 -: SEL_BITS].
- TIMEOUT, 15, maximum wait cycles for s_ready before an error response; legal range 1 to 255.

Ports:
- clk  in  1  the single clock; all logic is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- m_req  in  1  master request, sampled only in IDLE.
- m_addr  in  32  byte address.
- m_wdata  in  32  write data.
- m_wstrb  in  4  byte write strobes; 0 means read.
- m_ready  out  1  one-cycle response pulse.
- m_rdata  out  32  read data, valid with m_ready.
- m_err  out  1  error flag, valid with m_ready.
- s_req  out  NUM_SLAVES  one-hot slave request.
- s_addr  out  32  latched address, shared by all slaves.
- s_wdata  out  32  latched write data, shared.
- s_wstrb  out  4  latched strobes, shared.
- s_ready  in  NUM_SLAVES  per-slave completion.
- s_rdata  in  32*NUM_SLAVES  slave i occupies bits [32*i +: 32].
- err_count  out  8  saturating count of error responses.
- err_addr  out  32  address of the most recent error.

## Operation
- State machine with states IDLE, WAIT and RESP.
- IDLE: when m_req=1, latch m_addr, m_wdata and m_wstrb into s_addr, s_wdata and s_wstrb. Compute sel = m_addr[31 -: SEL_BITS].
  - If sel < NUM_SLAVES: go to WAIT, set s_req = 1<<sel, clear the wait counter.
  - If sel >= NUM_SLAVES: go to RESP with err=1. No s_req is asserted.
- WAIT: s_req[sel] is held high.
  - If s_ready[sel]=1: latch s_rdata[32*sel +: 32] as the response data (forced to 0 when the latched s_wstrb != 0). Clear s_req and go to RESP with err=0.
  - Otherwise, if counter == TIMEOUT-1: clear s_req and go to RESP with err=1.
  - Otherwise increment the counter.
  - s_ready bits of non-selected slaves are ignored.
- RESP: drive m_ready=1 for exactly one cycle with m_rdata and m_err, then return to IDLE.
  - On err: m_rdata=0; err_count increments and saturates at 255; err_addr is loaded with s_addr.
  - A new m_req is only accepted in IDLE. m_req asserted during WAIT or RESP is ignored, and the master must re-present it.
- The latched s_addr, s_wdata and s_wstrb change only on acceptance in IDLE.

## Timing
- Reset values:
  - state=IDLE.
  - s_req=0, m_ready=0, m_err=0.
  - m_rdata=0, s_addr=0, s_wdata=0, s_wstrb=0.
  - err_count=0, err_addr=0, wait counter=0.
- Mapped access with s_ready high on the first WAIT cycle:
  - req sampled on edge 0; s_req high in cycle 1.
  - s_ready sampled on edge 1; m_ready high in cycle 2.
  - Minimum latency is 2 cycles from the request edge to m_ready.
- Each extra cycle of s_ready=0 adds one cycle of latency.
- Timeout: s_req stays high for exactly TIMEOUT cycles, then m_ready and m_err are asserted the following cycle.
- If s_ready rises in the same cycle the counter reaches TIMEOUT-1, s_ready wins: no error.
- Unmapped access: m_ready and m_err are high in cycle 1, i.e. 1-cycle latency.
- Back-to-back: the earliest next acceptance is the IDLE cycle after RESP, giving a throughput of 1 transfer per 3 cycles.
- Reset asserted in any state returns all outputs to reset values at the next edge. s_req drops and no m_ready pulse is issued for the aborted transfer.

## Test plan
- Read from slave 0 at address 0x0000_0010, s_ready tied high, s_rdata[31:0]=0xDEADBEEF -> s_req=0b0000001 for 1 cycle, then m_ready=1 with m_rdata=0xDEADBEEF and m_err=0, 2 cycles after the request.
- Write 0x12345678 with strobes 0xF to address 0x6000_0000 (slave 3), s_ready delayed by 4 cycles -> s_wdata=0x12345678 and s_req[3]=1 for 5 cycles, then m_ready with m_rdata=0 and m_err=0.
- Read from slave 2 with s_ready never asserted, TIMEOUT=15 -> s_req[2] high for 15 cycles, then m_err=1, err_count=1, err_addr=0x4000_0000.
- NUM_SLAVES=7, access to address 0xE000_0004 (sel=7) -> no s_req, m_ready and m_err=1 in the next cycle, err_addr=0xE000_0004.
- 260 consecutive unmapped accesses -> err_count saturates at 255.
- Assert rst during WAIT on slave 1 -> s_req=0 after the next edge, no m_ready pulse, err_count unchanged.
- m_req pulsed during WAIT and during RESP -> ignored, s_addr unchanged.

Source files
------------

// File: rtl/mmio_fabric_if.sv
// CPU-side and peripheral-side bus signals of the MMIO fabric.
// The slave modport is the fabric's view; master is the environment driving it.
interface mmio_fabric_if #(
    parameter int unsigned NUM_SLAVES = 7
);
    logic                         m_req;
    logic [31:0]                  m_addr;
    logic [31:0]                  m_wdata;
    logic [3:0]                   m_wstrb;
    logic                         m_ready;
    logic [31:0]                  m_rdata;
    logic                         m_err;
    logic [NUM_SLAVES-1:0]        s_req;
    logic [31:0]                  s_addr;
    logic [31:0]                  s_wdata;
    logic [3:0]                   s_wstrb;
    logic [NUM_SLAVES-1:0]        s_ready;
    logic [32*NUM_SLAVES-1:0]     s_rdata;

    modport slave (
        input  m_req, m_addr, m_wdata, m_wstrb, s_ready, s_rdata,
        output m_ready, m_rdata, m_err, s_req, s_addr, s_wdata, s_wstrb
    );

    modport master (
        output m_req, m_addr, m_wdata, m_wstrb, s_ready, s_rdata,
        input  m_ready, m_rdata, m_err, s_req, s_addr, s_wdata, s_wstrb
    );
endinterface

// File: rtl/mmio_fabric.sv
// Registered request/ready interconnect from the CPU data port to NUM_SLAVES regions,
// with per-slave wait states, a bus timeout and sticky error status.
module mmio_fabric #(
    parameter int unsigned NUM_SLAVES = 7,
    parameter int unsigned SEL_BITS   = 3,
    parameter int unsigned TIMEOUT    = 15
) (
    input  logic         clk,
    input  logic         rst,
    mmio_fabric_if.slave bus,
    output logic [7:0]   err_count,
    output logic [31:0]  err_addr
);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e                r_state;
    logic [NUM_SLAVES-1:0] r_s_req;
    logic [7:0]            r_cnt;
    logic                  r_m_ready;
    logic                  r_m_err;
    logic [31:0]           r_m_rdata;
    logic [31:0]           r_s_addr;
    logic [31:0]           r_s_wdata;
    logic [3:0]            r_s_wstrb;
    logic [7:0]            r_err_count;
    logic [31:0]           r_err_addr;

    logic [SEL_BITS-1:0]   w_sel;
    logic                  w_mapped;
    logic [NUM_SLAVES-1:0] w_onehot;
    logic                  w_ready;
    logic [31:0]           w_rdata;

    assign w_sel    = bus.m_addr[31 -: SEL_BITS];
    assign w_mapped = 32'(w_sel) < NUM_SLAVES;
    // r_s_req is one-hot while waiting, so it doubles as the slave select.
    assign w_ready  = |(bus.s_ready & r_s_req);

    always_comb begin
        w_onehot = '0;
        w_rdata  = '0;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            w_onehot[i] = (32'(w_sel) == 32'(i));
            if (r_s_req[i]) begin
                w_rdata = bus.s_rdata[32*i +: 32];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= StIdle;
            r_s_req     <= '0;
            r_cnt       <= '0;
            r_m_ready   <= 1'b0;
            r_m_err     <= 1'b0;
            r_m_rdata   <= '0;
            r_s_addr    <= '0;
            r_s_wdata   <= '0;
            r_s_wstrb   <= '0;
            r_err_count <= '0;
            r_err_addr  <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (bus.m_req) begin
                        r_s_addr  <= bus.m_addr;
                        r_s_wdata <= bus.m_wdata;
                        r_s_wstrb <= bus.m_wstrb;
                        if (w_mapped) begin
                            r_s_req <= w_onehot;
                            r_cnt   <= '0;
                            r_state <= StWait;
                        end else begin
                            r_m_ready  <= 1'b1;
                            r_m_err    <= 1'b1;
                            r_m_rdata  <= '0;
                            r_err_addr <= bus.m_addr;
                            if (r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
                            r_state    <= StResp;
                        end
                    end
                end
                StWait: begin
                    // A ready arriving on the last allowed cycle still completes cleanly.
                    if (w_ready) begin
                        r_s_req   <= '0;
                        r_m_ready <= 1'b1;
                        r_m_err   <= 1'b0;
                        r_m_rdata <= (r_s_wstrb != 4'h0) ? 32'h0 : w_rdata;
                        r_state   <= StResp;
                    end else if (r_cnt == 8'(TIMEOUT - 1)) begin
                        r_s_req    <= '0;
                        r_m_ready  <= 1'b1;
                        r_m_err    <= 1'b1;
                        r_m_rdata  <= '0;
                        r_err_addr <= r_s_addr;
                        if (r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
                        r_state    <= StResp;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                StResp: begin
                    r_m_ready <= 1'b0;
                    r_m_err   <= 1'b0;
                    r_m_rdata <= '0;
                    r_state   <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign bus.m_ready = r_m_ready;
    assign bus.m_err   = r_m_err;
    assign bus.m_rdata = r_m_rdata;
    assign bus.s_req   = r_s_req;
    assign bus.s_addr  = r_s_addr;
    assign bus.s_wdata = r_s_wdata;
    assign bus.s_wstrb = r_s_wstrb;
    assign err_count   = r_err_count;
    assign err_addr    = r_err_addr;

endmodule

// File: tb/tb_mmio_fabric.sv
// Randomized scoreboard bench for mmio_fabric: the driver pushes expected responses
// computed from the address map and slave delay; a monitor checks each m_ready pulse.
module tb_mmio_fabric;

    localparam int unsigned NS = 7;
    localparam int unsigned TO = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  err_count;
    logic [31:0] err_addr;
    int          cyc = 0;

    mmio_fabric_if #(.NUM_SLAVES(NS)) bus ();

    mmio_fabric #(
        .NUM_SLAVES(NS),
        .SEL_BITS  (3),
        .TIMEOUT   (TO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .err_count(err_count),
        .err_addr (err_addr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int          cyc;
        logic [7:0]  ecnt;
        logic [31:0] eaddr;
    } exp_t;

    exp_t        q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [7:0]  m_ecnt;
    logic [31:0] m_eaddr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Issue one transfer at the current negedge. d = cycles of s_ready low before the
    // selected slave answers; d >= TO means it never answers.
    task automatic txn(input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] wstrb, input int d, input logic [31:0] sdata);
        int             sel;
        bit             mapped;
        int             lat;
        exp_t           e;
        logic [NS-1:0]  oh;
        logic [NS-1:0]  noise;
        sel    = int'(addr[31:29]);
        mapped = (sel < int'(NS));
        oh     = mapped ? (NS'(1) << sel) : '0;
        for (int i = 0; i < int'(NS); i++) begin
            bus.s_rdata[32*i +: 32] = (i == sel) ? sdata : $urandom;
        end
        if (!mapped)           begin lat = 0;     e.err = 1'b1; end
        else if (d >= int'(TO)) begin lat = int'(TO); e.err = 1'b1; end
        else                   begin lat = 1 + d; e.err = 1'b0; end
        e.addr  = addr;
        e.wdata = wdata;
        e.rdata = (e.err || wstrb != 4'h0) ? 32'h0 : sdata;
        if (e.err) begin
            if (m_ecnt != 8'hFF) m_ecnt = m_ecnt + 8'd1;
            m_eaddr = addr;
        end
        e.ecnt  = m_ecnt;
        e.eaddr = m_eaddr;
        e.cyc   = cyc + 1 + lat;
        q.push_back(e);
        bus.m_req   = 1'b1;
        bus.m_addr  = addr;
        bus.m_wdata = wdata;
        bus.m_wstrb = wstrb;
        for (int j = 1; j <= lat + 2; j++) begin
            @(negedge clk);
            // Stray requests while busy must be ignored; stop them on the IDLE cycle.
            bus.m_req   = (j <= lat + 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.m_addr  = $urandom;
            bus.m_wdata = $urandom;
            bus.m_wstrb = 4'($urandom);
            noise       = NS'($urandom) & ~oh;
            bus.s_ready = noise | ((mapped && j <= lat && (j - 1) >= d) ? oh : '0);
            check("s_req", 32'(bus.s_req), (mapped && j <= lat) ? 32'(oh) : 32'h0);
        end
    endtask

    // Monitor: every response pulse is matched against the head of the queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.m_ready === 1'b1) begin
                if (q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_m_ready: got m_ready=1, expected none (t=%0t)",
                             $time);
                end else begin
                    e = q.pop_front();
                    check("m_rdata", bus.m_rdata, e.rdata);
                    check("m_err", 32'(bus.m_err), 32'(e.err));
                    check("resp_cycle", 32'(cyc), 32'(e.cyc));
                    check("s_addr_held", bus.s_addr, e.addr);
                    check("s_wdata_held", bus.s_wdata, e.wdata);
                    @(negedge clk);
                    check("err_count", 32'(err_count), 32'(e.ecnt));
                    check("err_addr", err_addr, e.eaddr);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] sel;
        bus.m_req   = 1'b0;
        bus.m_addr  = '0;
        bus.m_wdata = '0;
        bus.m_wstrb = '0;
        bus.s_ready = '0;
        bus.s_rdata = '0;
        m_ecnt      = '0;
        m_eaddr     = '0;
        repeat (3) @(negedge clk);
        check("rst_s_req", 32'(bus.s_req), 32'h0);
        check("rst_m_ready", 32'(bus.m_ready), 32'h0);
        check("rst_m_err", 32'(bus.m_err), 32'h0);
        check("rst_m_rdata", bus.m_rdata, 32'h0);
        check("rst_s_addr", bus.s_addr, 32'h0);
        check("rst_s_wdata", bus.s_wdata, 32'h0);
        check("rst_s_wstrb", 32'(bus.s_wstrb), 32'h0);
        check("rst_err_count", 32'(err_count), 32'h0);
        check("rst_err_addr", err_addr, 32'h0);
        rst = 1'b0;

        // Abort a transfer to slave 1 with reset while it waits.
        @(negedge clk);
        bus.m_req  = 1'b1;
        bus.m_addr = 32'h2000_0040;
        @(negedge clk);
        bus.m_req  = 1'b0;
        check("abort_s_req_wait", 32'(bus.s_req), 32'h2);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_s_req", 32'(bus.s_req), 32'h0);
        check("abort_m_ready", 32'(bus.m_ready), 32'h0);
        check("abort_err_count", 32'(err_count), 32'h0);
        rst = 1'b0;
        bus.s_ready = '1;
        repeat (10) @(negedge clk);
        bus.s_ready = '0;

        txn(32'h0000_0010, 32'h0, 4'h0, 0, 32'hDEAD_BEEF);
        txn(32'h6000_0000, 32'h1234_5678, 4'hF, 4, 32'hCAFE_F00D);
        txn(32'h4000_0000, 32'h0, 4'h0, int'(TO), 32'h1111_2222);
        txn(32'hE000_0004, 32'h0, 4'h0, 0, 32'h3333_4444);
        txn(32'hA000_0100, 32'h0, 4'h0, int'(TO) - 1, 32'h5555_6666);
        txn(32'hA000_0200, 32'h0, 4'h0, int'(TO), 32'h7777_8888);

        for (int k = 0; k < 150; k++) begin
            sel = 3'($urandom_range(0, 7));
            txn({sel, 29'($urandom)}, $urandom,
                ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0,
                $urandom_range(0, int'(TO) + 2), $urandom);
        end

        for (int k = 0; k < 260; k++) begin
            txn({3'b111, 29'($urandom)}, $urandom, 4'($urandom), 0, $urandom);
        end

        txn(32'h2000_0008, 32'h0, 4'h0, 1, 32'h0BAD_F00D);

        repeat (5) @(negedge clk);
        check("scoreboard_drained", 32'(q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
